// File: rtl/usb_sniffer_pkg.sv
// Shared definitions for the USB sniffer FX2 write path: word width, packet size,
// source-select encoding and the per-cycle write-port action.
package usb_sniffer_pkg;

    localparam int FX2_W         = 16;
    localparam int FX2_PKT_WORDS = 256;

    typedef enum logic {
        SRC_DATA = 1'b0,
        SRC_MARK = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_WR     = 2'd1,
        ACT_PKTEND = 2'd2
    } act_e;

    // One-hot grant {mark, data} to source encoding.
    function automatic src_e src_of_gnt(input logic [1:0] gnt);
        return (gnt == 2'b10) ? SRC_MARK : SRC_DATA;
    endfunction

endpackage

// File: rtl/fx2_wr_sched_if.sv
// Write-side bundle for the FX2 scheduler: source handshakes, FIFO flag and the
// registered write port. slave = scheduler, master = whatever drives the sources.
interface fx2_wr_sched_if
    import usb_sniffer_pkg::*;
#(
    parameter int W     = FX2_W,
    parameter int CNT_W = 16
);
    // Handshake: a source holds its word with *_valid_i=1 (show-ahead); the word is
    // consumed in exactly the cycle its *_ack_o is 1, and the source may then
    // present the next word on the following cycle.
    logic             enable_i;
    logic             flush_i;
    logic [W-1:0]     data_i;
    logic             data_valid_i;
    logic             data_ack_o;
    logic [W-1:0]     mark_i;
    logic             mark_valid_i;
    logic             mark_ack_o;
    logic             if_ready_i;
    logic             slwr_o;
    logic             pktend_o;
    logic [W-1:0]     fd_o;
    logic [CNT_W-1:0] pkt_cnt_o;
    logic             busy_o;
    act_e             dbg_act_o;

    modport slave (
        input  enable_i, flush_i, data_i, data_valid_i, mark_i, mark_valid_i, if_ready_i,
        output data_ack_o, mark_ack_o, slwr_o, pktend_o, fd_o, pkt_cnt_o, busy_o, dbg_act_o
    );

    modport master (
        output enable_i, flush_i, data_i, data_valid_i, mark_i, mark_valid_i, if_ready_i,
        input  data_ack_o, mark_ack_o, slwr_o, pktend_o, fd_o, pkt_cnt_o, busy_o, dbg_act_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, last-grant register.
// Req/grant bit 0 = SRC_DATA, bit 1 = SRC_MARK.
module rr_arb2
    import usb_sniffer_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    src_e r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = (r_last == SRC_DATA) ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_last <= SRC_DATA;
        end else if (|o_gnt) begin
            r_last <= src_of_gnt(o_gnt);
        end
    end

endmodule

// File: rtl/fx2_wr_sched.sv
// FX2 slave-FIFO write scheduler: arbitrates capture and marker words onto fd/slwr,
// tracks endpoint packet fill and commits partial packets with pktend.
module fx2_wr_sched
    import usb_sniffer_pkg::*;
#(
    parameter int W            = FX2_W,
    parameter int PKT_WORDS    = FX2_PKT_WORDS,
    parameter int IDLE_TIMEOUT = 4096,
    parameter int CNT_W        = 16
) (
    input logic             clk_i,
    input logic             reset_n_i,
    fx2_wr_sched_if.slave   bus
);

    localparam int WC_W = $clog2(PKT_WORDS);
    localparam int IC_W = $clog2(IDLE_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(PKT_WORDS - 1);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(IDLE_TIMEOUT - 1);

    logic             r_slwr;
    logic             r_pktend;
    logic [W-1:0]     r_fd;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [WC_W-1:0]  r_word_cnt;
    logic [IC_W-1:0]  r_idle_cnt;
    logic             r_flush_pend;
    act_e             r_act;

    logic             w_pktend_due;
    logic             w_pktend_go;
    logic             w_arb_en;
    logic [1:0]       w_gnt;
    logic             w_grant;
    logic             w_wrap;
    logic [W-1:0]     w_word;

    // A due pktend owns the slot; grants are gated by reset so acks drop at once.
    assign w_pktend_due = (r_flush_pend || (r_idle_cnt == IC_LAST)) && (r_word_cnt != '0);
    assign w_pktend_go  = bus.if_ready_i && w_pktend_due;
    assign w_arb_en     = reset_n_i && bus.if_ready_i && !w_pktend_due && bus.enable_i;

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_en      (w_arb_en),
        .i_req     ({bus.mark_valid_i, bus.data_valid_i}),
        .o_gnt     (w_gnt)
    );

    assign w_grant = |w_gnt;
    assign w_wrap  = w_grant && (r_word_cnt == WC_LAST);
    assign w_word  = w_gnt[1] ? bus.mark_i : bus.data_i;

    assign bus.data_ack_o = w_gnt[0];
    assign bus.mark_ack_o = w_gnt[1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_slwr       <= 1'b0;
            r_pktend     <= 1'b0;
            r_fd         <= '0;
            r_pkt_cnt    <= '0;
            r_word_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_act        <= ACT_NONE;
        end else begin
            r_slwr   <= w_grant;
            r_pktend <= w_pktend_go;

            if (w_grant) begin
                r_fd  <= w_word;
                r_act <= ACT_WR;
            end else if (w_pktend_go) begin
                r_act <= ACT_PKTEND;
            end else begin
                r_act <= ACT_NONE;
            end

            // A full packet is committed by the FX2 itself, so wrap just counts it.
            if (w_pktend_go) begin
                r_word_cnt <= '0;
            end else if (w_grant) begin
                r_word_cnt <= w_wrap ? '0 : r_word_cnt + 1'b1;
            end

            if (w_pktend_go || w_wrap) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end

            // Never latch a flush that would produce a zero-length packet.
            if (w_pktend_go || w_wrap) begin
                r_flush_pend <= 1'b0;
            end else if (bus.flush_i && ((r_word_cnt != '0) || w_grant)) begin
                r_flush_pend <= 1'b1;
            end

            if (w_grant || w_pktend_go || (r_word_cnt == '0)) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IC_LAST) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign bus.slwr_o    = r_slwr;
    assign bus.pktend_o  = r_pktend;
    assign bus.fd_o      = r_fd;
    assign bus.pkt_cnt_o = r_pkt_cnt;
    assign bus.busy_o    = (r_word_cnt != '0) || r_flush_pend;
    assign bus.dbg_act_o = r_act;

endmodule
